// File: rtl/ex_muldiv_pkg.sv
// Shared opcodes, FSM encodings and engine op selector for the ex_muldiv execute stage.
package ex_muldiv_pkg;

  localparam logic [7:0] ALU_ADD  = 8'h01;
  localparam logic [7:0] ALU_SUB  = 8'h02;
  localparam logic [7:0] ALU_AND  = 8'h03;
  localparam logic [7:0] ALU_OR   = 8'h04;
  localparam logic [7:0] ALU_XOR  = 8'h05;
  localparam logic [7:0] ALU_NOT  = 8'h06;
  localparam logic [7:0] ALU_SLL  = 8'h07;
  localparam logic [7:0] ALU_SRL  = 8'h08;
  localparam logic [7:0] ALU_SRA  = 8'h09;
  localparam logic [7:0] ALU_SLT  = 8'h0A;
  localparam logic [7:0] ALU_SLTU = 8'h0B;
  localparam logic [7:0] ALU_MUL  = 8'h0C;
  localparam logic [7:0] ALU_DIVU = 8'h0D;
  localparam logic [7:0] ALU_MFHI = 8'h0E;
  localparam logic [7:0] ALU_MTHI = 8'h0F;

  localparam logic [1:0] EX_IDLE = 2'd0;
  localparam logic [1:0] EX_BUSY = 2'd1;
  localparam logic [1:0] EX_DONE = 2'd2;

  typedef enum logic {MD_MUL = 1'b0, MD_DIVU = 1'b1} md_op_e;

endpackage

// File: rtl/ex_muldiv_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine, one bit per cycle.
module muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [DATA_W-1:0] hi_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        state_q, state_d;
  logic              op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W:0]   mul_sum, div_shift, div_diff;

  // hi:lo doubles as product accumulator (MUL) or remainder:quotient (DIVU)
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      EX_IDLE: begin
        if (start_i) begin
          op_d = op_i;
          if (op_i == MD_DIVU && b_i == '0) begin
            hi_d    = a_i;
            lo_d    = '1;
            state_d = EX_DONE;
          end else begin
            cnt_d   = '0;
            hi_d    = '0;
            b_d     = (op_i == MD_MUL) ? a_i : b_i;
            lo_d    = (op_i == MD_MUL) ? b_i : a_i;
            state_d = EX_BUSY;
          end
        end
      end
      EX_BUSY: begin
        if (flush_i) begin
          state_d = EX_IDLE;
        end else begin
          if (op_q == MD_DIVU) begin
            if (!div_diff[DATA_W]) begin
              hi_d = div_diff[DATA_W-1:0];
              lo_d = {lo_q[DATA_W-2:0], 1'b1};
            end else begin
              hi_d = div_shift[DATA_W-1:0];
              lo_d = {lo_q[DATA_W-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[DATA_W:1];
            lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = EX_DONE;
        end
      end
      default: state_d = EX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EX_IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o = (state_q == EX_BUSY);
  assign done_o = (state_q == EX_DONE);
  assign lo_o   = lo_q;
  assign hi_o   = hi_q;

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: combinational ALU, HI register, and stall control around the iterative mul/div engine.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int ALUOP_W    = 8,
  parameter int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluOp_i,
  input  logic [DATA_W-1:0]     operand1_i,
  input  logic [DATA_W-1:0]     operand2_i,
  input  logic                  wReg_i,
  input  logic [REG_ADDR_W-1:0] wRegAddr_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     wData_o,
  output logic                  wReg_o,
  output logic [REG_ADDR_W-1:0] wRegAddr_o,
  output logic                  stallReq_o
);

  logic [DATA_W-1:0]  hi_q, hi_d, alu_res, md_lo, md_hi;
  logic [SHAMT_W-1:0] shamt;
  logic               md_busy, md_done, idle, is_mul, is_md, md_start;

  assign shamt    = operand2_i[SHAMT_W-1:0];
  assign is_mul   = (aluOp_i == ALUOP_W'(ALU_MUL));
  assign is_md    = is_mul || (aluOp_i == ALUOP_W'(ALU_DIVU));
  assign idle     = !md_busy && !md_done;
  assign md_start = idle && is_md && !flush_i;

  muldiv_unit #(.DATA_W(DATA_W)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (!is_mul),
    .a_i     (operand1_i),
    .b_i     (operand2_i),
    .flush_i (flush_i),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  always_comb begin
    alu_res = '0;
    case (aluOp_i)
      ALUOP_W'(ALU_ADD):  alu_res = operand1_i + operand2_i;
      ALUOP_W'(ALU_SUB):  alu_res = operand1_i - operand2_i;
      ALUOP_W'(ALU_AND):  alu_res = operand1_i & operand2_i;
      ALUOP_W'(ALU_OR):   alu_res = operand1_i | operand2_i;
      ALUOP_W'(ALU_XOR):  alu_res = operand1_i ^ operand2_i;
      ALUOP_W'(ALU_NOT):  alu_res = ~operand1_i;
      ALUOP_W'(ALU_SLL):  alu_res = operand1_i << shamt;
      ALUOP_W'(ALU_SRL):  alu_res = operand1_i >> shamt;
      ALUOP_W'(ALU_SRA):  alu_res = $signed(operand1_i) >>> shamt;
      ALUOP_W'(ALU_SLT):  alu_res = DATA_W'($signed(operand1_i) < $signed(operand2_i));
      ALUOP_W'(ALU_SLTU): alu_res = DATA_W'(operand1_i < operand2_i);
      ALUOP_W'(ALU_MFHI): alu_res = hi_q;
      default:            alu_res = '0;
    endcase
  end

  // MTHI only lands while idle; a stalled pipeline keeps it away from DONE
  always_comb begin
    hi_d = hi_q;
    if (md_done && !flush_i)                           hi_d = md_hi;
    else if (idle && aluOp_i == ALUOP_W'(ALU_MTHI))    hi_d = operand1_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hi_q <= '0;
    else     hi_q <= hi_d;
  end

  always_comb begin
    wData_o    = '0;
    wReg_o     = 1'b0;
    wRegAddr_o = wRegAddr_i;
    stallReq_o = 1'b0;
    if (rst) begin
      wRegAddr_o = '0;
    end else if (md_busy) begin
      stallReq_o = !flush_i;
    end else if (md_done) begin
      if (!flush_i) begin
        wData_o = md_lo;
        wReg_o  = wReg_i;
      end
    end else if (is_md) begin
      stallReq_o = !flush_i;
    end else begin
      wData_o = alu_res;
      wReg_o  = wReg_i;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv (DATA_W=16) with hand-computed expectations.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluOp_i;
  logic [15:0] operand1_i, operand2_i;
  logic        wReg_i;
  logic [3:0]  wRegAddr_i;
  logic        flush_i;
  logic [15:0] wData_o;
  logic        wReg_o;
  logic [3:0]  wRegAddr_o;
  logic        stallReq_o;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.DATA_W(16), .REG_ADDR_W(4), .ALUOP_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluOp_i    (aluOp_i),
    .operand1_i (operand1_i),
    .operand2_i (operand2_i),
    .wReg_i     (wReg_i),
    .wRegAddr_i (wRegAddr_i),
    .flush_i    (flush_i),
    .wData_o    (wData_o),
    .wReg_o     (wReg_o),
    .wRegAddr_o (wRegAddr_o),
    .stallReq_o (stallReq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic apply(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic we, input logic [3:0] addr);
    aluOp_i    = op;
    operand1_i = a;
    operand2_i = b;
    wReg_i     = we;
    wRegAddr_i = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op: result visible in the same cycle
  task automatic alu(input string tag, input logic [7:0] op, input logic [15:0] a,
                     input logic [15:0] b, input logic [15:0] exp);
    apply(op, a, b, 1'b1, 4'd3);
    @(negedge clk);
    chk(tag, 32'(wData_o), 32'(exp));
    chk({tag, "_stall"}, 32'(stallReq_o), 32'd0);
    tick();
  endtask

  // Hold a MUL/DIVU on the inputs while stalled, then check the DONE cycle and MFHI
  task automatic run_md(input string tag, input logic [7:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int exp_stall,
                        input logic [15:0] exp_lo, input logic [15:0] exp_hi);
    int n = 0;
    apply(op, a, b, 1'b1, 4'd5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stallReq_o) break;
      n++;
      if (wReg_o !== 1'b0) chk({tag, "_wreg_stall"}, 32'(wReg_o), 32'd0);
      tick();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_result"}, 32'(wData_o), 32'(exp_lo));
    chk({tag, "_wreg_done"}, 32'(wReg_o), 32'd1);
    chk({tag, "_addr_done"}, 32'(wRegAddr_o), 32'd5);
    tick();
    apply(ALU_MFHI, 16'h0, 16'h0, 1'b1, 4'd6);
    @(negedge clk);
    chk({tag, "_mfhi"}, 32'(wData_o), 32'(exp_hi));
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    flush_i = 1'b0;
    apply(ALU_ADD, 16'h0001, 16'h0002, 1'b1, 4'd7);
    @(negedge clk);
    chk("rst_wdata", 32'(wData_o), 32'd0);
    chk("rst_wreg", 32'(wReg_o), 32'd0);
    chk("rst_addr", 32'(wRegAddr_o), 32'd0);
    chk("rst_stall", 32'(stallReq_o), 32'd0);
    tick();
    rst = 1'b0;

    alu("add_wrap", ALU_ADD, 16'h7FFF, 16'h0001, 16'h8000);
    chk("add_addr_pass", 32'(wRegAddr_o), 32'd3);
    alu("sra", ALU_SRA, 16'h8000, 16'h0003, 16'hF000);
    alu("slt", ALU_SLT, 16'hFFFF, 16'h0001, 16'h0001);
    alu("sltu", ALU_SLTU, 16'hFFFF, 16'h0001, 16'h0000);
    alu("sub_wrap", ALU_SUB, 16'h0000, 16'h0001, 16'hFFFF);
    alu("sll", ALU_SLL, 16'h0001, 16'h0014, 16'h0010);
    alu("xor", ALU_XOR, 16'hF0F0, 16'hFF00, 16'h0FF0);
    alu("not", ALU_NOT, 16'h1234, 16'h0000, 16'hEDCB);
    alu("unknown", 8'hFF, 16'h1234, 16'h5678, 16'h0000);

    run_md("mul", ALU_MUL, 16'h1234, 16'h0100, 17, 16'h3400, 16'h0012);
    run_md("divu", ALU_DIVU, 16'd100, 16'd7, 17, 16'h000E, 16'h0002);
    run_md("div0", ALU_DIVU, 16'd5, 16'd0, 1, 16'hFFFF, 16'h0005);

    alu("mthi", ALU_MTHI, 16'hAAAA, 16'h0000, 16'h0000);
    apply(ALU_MUL, 16'd3, 16'd4, 1'b1, 4'd8);
    tick();
    repeat (4) tick();
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_stall", 32'(stallReq_o), 32'd0);
    chk("flush_wreg", 32'(wReg_o), 32'd0);
    tick();
    flush_i = 1'b0;
    apply(ALU_MFHI, 16'h0, 16'h0, 1'b1, 4'd8);
    @(negedge clk);
    chk("flush_idle_stall", 32'(stallReq_o), 32'd0);
    chk("flush_mfhi", 32'(wData_o), 32'hAAAA);
    tick();

    apply(ALU_DIVU, 16'd100, 16'd7, 1'b1, 4'd9);
    tick();
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("midrst_wdata", 32'(wData_o), 32'd0);
    chk("midrst_wreg", 32'(wReg_o), 32'd0);
    chk("midrst_addr", 32'(wRegAddr_o), 32'd0);
    chk("midrst_stall", 32'(stallReq_o), 32'd0);
    tick();
    rst = 1'b0;
    apply(ALU_MFHI, 16'h0, 16'h0, 1'b1, 4'd9);
    @(negedge clk);
    chk("postrst_stall", 32'(stallReq_o), 32'd0);
    chk("postrst_mfhi", 32'(wData_o), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
